// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstgen_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__rstgen_pkg: state encoding and parameter limits shared by the reset generator.
package gf180mcu_fd_sc_mcu7t5v0__rstgen_pkg;
   localparam logic [1:0] ST_ASSERT = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_SWRST  = 2'd3;
   typedef enum logic [1:0] {
      ASSERT = ST_ASSERT,
      HOLD   = ST_HOLD,
      RUN    = ST_RUN,
      SWRST  = ST_SWRST
   } state_t;
   localparam int MIN_SYNC_STAGES = 2;
   localparam int MIN_HOLD_CYCLES = 1;
   function automatic logic params_ok(input int sync_stages, input int hold_cycles);
      return (sync_stages >= MIN_SYNC_STAGES) && (hold_cycles >= MIN_HOLD_CYCLES);
   endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstgen_sync.sv
// gf180mcu_fd_sc_mcu7t5v0__rstgen_sync: release synchronizer, a chain of ones shifted in once RN is high.
// o_sync_d is the value the last stage takes on the coming edge, so the FSM can act on that same edge.
module gf180mcu_fd_sc_mcu7t5v0__rstgen_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rn,
   output logic o_sync,
   output logic o_sync_d
);
   logic [SYNC_STAGES-1:0] r_chain;
   always_ff @(posedge i_clk or negedge i_rn)
      if (!i_rn) r_chain <= '0;
      else r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
   assign o_sync   = r_chain[SYNC_STAGES-1];
   assign o_sync_d = r_chain[SYNC_STAGES-2];
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstgen_func.sv
// gf180mcu_fd_sc_mcu7t5v0__rstgen_func: async-assert / sync-deassert reset generator with a hold counter.
// Optional software reset handshake under `GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN; supplies under `USE_POWER_PINS.
module gf180mcu_fd_sc_mcu7t5v0__rstgen_func
   import gf180mcu_fd_sc_mcu7t5v0__rstgen_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16
) (
`ifdef USE_POWER_PINS
   inout  wire  VDD,
   inout  wire  VSS,
`endif
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
   input  logic SW_REQ,
   output logic SW_ACK,
`endif
   input  logic CLK,
   input  logic RN,
   output logic RN_OUT,
   output logic RST_DONE
);
   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES);

   if (!params_ok(SYNC_STAGES, HOLD_CYCLES)) begin : g_bad_params
      $error("rstgen: SYNC_STAGES must be >= 2 and HOLD_CYCLES >= 1");
   end

   state_t           r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n, w_cnt_inc;
   logic             r_rn_out, r_rn_q, r_done;
   logic             w_sync, w_sync_d;

   gf180mcu_fd_sc_mcu7t5v0__rstgen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk    (CLK),
      .i_rn     (RN),
      .o_sync   (w_sync),
      .o_sync_d (w_sync_d)
   );

   assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;

`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
   // r_arm: SW_REQ must be seen low in RUN before a request counts, so a level held from power-on never fires
   logic r_ack, w_ack_n, r_arm, w_arm_n, w_trig;
   assign w_trig = SW_REQ && !r_ack && r_arm;
`endif

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
      w_ack_n   = r_ack & SW_REQ;
      w_arm_n   = r_arm;
`endif
      case (r_state)
         ASSERT:
            if (w_sync_d) begin
               w_cnt_n   = CNT_ONE;
               w_state_n = (CNT_ONE == CNT_MAX) ? RUN : HOLD;
            end
         HOLD:
            if (!w_sync) begin
               w_cnt_n   = '0;
               w_state_n = ASSERT;
            end else begin
               w_cnt_n   = w_cnt_inc;
               w_state_n = (w_cnt_inc == CNT_MAX) ? RUN : HOLD;
            end
         RUN: begin
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
            w_arm_n = w_trig ? 1'b0 : (r_arm | ~SW_REQ);
            if (w_trig) begin
               w_cnt_n   = '0;
               w_state_n = SWRST;
            end
`endif
         end
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
         SWRST: begin
            w_cnt_n = w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) begin
               w_state_n = RUN;
               w_ack_n   = 1'b1;
            end
         end
`endif
         default: begin
            w_cnt_n   = '0;
            w_state_n = ASSERT;
         end
      endcase
   end

   // RN_OUT comes straight from a flop so it can never glitch high on a state decode
   always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
         r_state  <= ASSERT;
         r_cnt    <= '0;
         r_rn_out <= 1'b0;
         r_rn_q   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_rn_out <= (w_state_n == RUN);
         r_rn_q   <= r_rn_out;
         r_done   <= r_rn_out & ~r_rn_q;
      end

`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
   always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
         r_ack <= 1'b0;
         r_arm <= 1'b0;
      end else begin
         r_ack <= w_ack_n;
         r_arm <= w_arm_n;
      end
   assign SW_ACK = r_ack;
`endif

   assign RN_OUT   = r_rn_out;
   assign RST_DONE = r_done;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rstgen_func.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__rstgen_func: directed and random checks of release latency, glitch restart and async assert.
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu7t5v0__rstgen_func;
   logic clk = 1'b0;
   logic rn_a = 1'b1, rn_b = 1'b1;
   logic out_a, done_a, out_b, done_b;
   int   n_chk = 0, n_fail = 0;
   int   k_a = 0, k_b = 0;
   localparam int LAT_A = 5;
   localparam int LAT_B = 3;
`ifdef USE_POWER_PINS
   wire vdd = 1'b1;
   wire vss = 1'b0;
`endif
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
   logic sw_req = 1'b0, sw_ack_a, sw_ack_b;
   logic sw_req_b = 1'b0;
`endif

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu7t5v0__rstgen_func #(.SYNC_STAGES(2), .HOLD_CYCLES(4)) dut_a (
`ifdef USE_POWER_PINS
      .VDD(vdd), .VSS(vss),
`endif
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
      .SW_REQ(sw_req), .SW_ACK(sw_ack_a),
`endif
      .CLK(clk), .RN(rn_a), .RN_OUT(out_a), .RST_DONE(done_a)
   );

   gf180mcu_fd_sc_mcu7t5v0__rstgen_func #(.SYNC_STAGES(3), .HOLD_CYCLES(1)) dut_b (
`ifdef USE_POWER_PINS
      .VDD(vdd), .VSS(vss),
`endif
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
      .SW_REQ(sw_req_b), .SW_ACK(sw_ack_b),
`endif
      .CLK(clk), .RN(rn_b), .RN_OUT(out_b), .RST_DONE(done_b)
   );

   // reference: count clock edges seen with RN continuously high since its last fall
   always @(posedge clk or negedge rn_a)
      if (!rn_a) k_a = 0;
      else if (k_a < 10000) k_a = k_a + 1;
   always @(posedge clk or negedge rn_b)
      if (!rn_b) k_b = 0;
      else if (k_b < 10000) k_b = k_b + 1;

   task automatic test_reset;
      #1;
      n_chk++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL reset_async_out_a: got %b want 0", out_a); end
      n_chk++; if (out_b !== 1'b0) begin n_fail++; $display("FAIL reset_async_out_b: got %b want 0", out_b); end
      repeat (3) begin
         @(negedge clk);
         n_chk++; if (out_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL reset_hold_a: got out=%b done=%b want 0 0", out_a, done_a); end
         n_chk++; if (out_b !== 1'b0 || done_b !== 1'b0) begin n_fail++; $display("FAIL reset_hold_b: got out=%b done=%b want 0 0", out_b, done_b); end
      end
   endtask

   task automatic test_release;
      @(negedge clk);
      #2 rn_a = 1'b1; rn_b = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_chk++; if (out_a !== (i >= 5)) begin n_fail++; $display("FAIL release_out_a edge %0d: got %b want %b", i, out_a, i >= 5); end
         n_chk++; if (done_a !== (i == 6)) begin n_fail++; $display("FAIL release_done_a edge %0d: got %b want %b", i, done_a, i == 6); end
         n_chk++; if (out_b !== (i >= 3)) begin n_fail++; $display("FAIL release_out_b edge %0d: got %b want %b", i, out_b, i >= 3); end
         n_chk++; if (done_b !== (i == 4)) begin n_fail++; $display("FAIL release_done_b edge %0d: got %b want %b", i, done_b, i == 4); end
         n_chk++; if (dut_b.r_cnt > 1) begin n_fail++; $display("FAIL cnt_b_bound edge %0d: got %0d want <=1", i, dut_b.r_cnt); end
      end
   endtask

   task automatic test_glitch;
      @(negedge clk);
      #2 rn_a = 1'b0;
      @(negedge clk);
      #2 rn_a = 1'b1;
      repeat (3) @(negedge clk);
      #2 rn_a = 1'b0;
      #2 rn_a = 1'b1;
      n_chk++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL glitch_out_low: got %b want 0", out_a); end
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         n_chk++; if (out_a !== (i >= 5)) begin n_fail++; $display("FAIL glitch_out edge %0d: got %b want %b", i, out_a, i >= 5); end
         n_chk++; if (done_a !== (i == 6)) begin n_fail++; $display("FAIL glitch_done edge %0d: got %b want %b", i, done_a, i == 6); end
      end
   endtask

   task automatic test_async_assert;
      @(negedge clk);
      #2;
      n_chk++; if (out_a !== 1'b1) begin n_fail++; $display("FAIL async_pre_run: got %b want 1", out_a); end
      rn_a = 1'b0;
      #1;
      n_chk++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL async_out: got %b want 0", out_a); end
      n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL async_done: got %b want 0", done_a); end
      @(negedge clk);
      #2 rn_a = 1'b1; rn_b = 1'b0;
      #1 rn_b = 1'b1;
   endtask

   task automatic test_random;
      int r;
      for (int it = 0; it < 400; it++) begin
         @(negedge clk);
         n_chk++; if (out_a !== (k_a >= LAT_A) || done_a !== (k_a == LAT_A + 1)) begin
            n_fail++; $display("FAIL rand_a it %0d k=%0d: got out=%b done=%b want %b %b", it, k_a, out_a, done_a, k_a >= LAT_A, k_a == LAT_A + 1);
         end
         n_chk++; if (out_b !== (k_b >= LAT_B) || done_b !== (k_b == LAT_B + 1)) begin
            n_fail++; $display("FAIL rand_b it %0d k=%0d: got out=%b done=%b want %b %b", it, k_b, out_b, done_b, k_b >= LAT_B, k_b == LAT_B + 1);
         end
         r = int'($urandom_range(0, 19));
         if (r == 0) begin
            #1 rn_a = 1'b0; rn_b = 1'b0;
            #($urandom_range(1, 3)) rn_a = 1'b1; rn_b = 1'b1;
         end else if (r <= 2 && rn_a) begin
            #3 rn_a = 1'b0; rn_b = 1'b0;
         end else if (r <= 8 && !rn_a) begin
            if ($urandom_range(0, 1) != 0) #3; else #7;
            rn_a = 1'b1; rn_b = 1'b1;
         end
      end
      @(negedge clk);
      #2 rn_a = 1'b1; rn_b = 1'b1;
      repeat (8) @(negedge clk);
   endtask

`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
   task automatic test_sw_held;
      @(negedge clk);
      #2 rn_a = 1'b0; sw_req = 1'b1;
      @(negedge clk);
      #2 rn_a = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         n_chk++; if (sw_ack_a !== 1'b0) begin n_fail++; $display("FAIL swheld_ack edge %0d: got %b want 0", i, sw_ack_a); end
         n_chk++; if (out_a !== (i >= 5)) begin n_fail++; $display("FAIL swheld_out edge %0d: got %b want %b", i, out_a, i >= 5); end
      end
   endtask

   task automatic test_sw_req;
      @(negedge clk);
      #2 sw_req = 1'b0;
      @(negedge clk);
      #2 sw_req = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         n_chk++; if (out_a !== (i >= 5)) begin n_fail++; $display("FAIL swreq_out edge %0d: got %b want %b", i, out_a, i >= 5); end
         n_chk++; if (sw_ack_a !== (i >= 5)) begin n_fail++; $display("FAIL swreq_ack edge %0d: got %b want %b", i, sw_ack_a, i >= 5); end
         n_chk++; if (done_a !== (i == 6)) begin n_fail++; $display("FAIL swreq_done edge %0d: got %b want %b", i, done_a, i == 6); end
      end
      #2 sw_req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_chk++; if (sw_ack_a !== 1'b0 || out_a !== 1'b1 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL swreq_release edge %0d: got ack=%b out=%b done=%b want 0 1 0", i, sw_ack_a, out_a, done_a);
         end
      end
   endtask
`endif

   initial begin
      #1 rn_a = 1'b0; rn_b = 1'b0;
      test_reset;
      test_release;
      test_glitch;
      test_async_assert;
      test_random;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RSTGEN_SWREQ_EN
      test_sw_held;
      test_sw_req;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
